// File: rtl/weight_tile_scheduler_pkg.sv
// Shared types and elaboration-time helpers for the weight tile scheduler.
package weight_tile_scheduler_pkg;

    // Per-tile sequencing states of the scheduler FSM
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LOAD,
        S_COMPUTE,
        S_WAIT_COMP,
        S_NEXT,
        S_DONE
    } state_e;

    // Number of weight words delivered by the filter for one K*K*Tm*Tn tile
    function automatic int words_per_tile(input int k, input int tm, input int tn);
        return k * k * tm * tn;
    endfunction

    // Number of tiles needed to cover a dimension d with tile size t
    function automatic int tile_count(input int d, input int t);
        return (d + t - 1) / t;
    endfunction

endpackage

// File: rtl/weight_tile_scheduler_tile_nest_counter.sv
// Four-level stepped loop nest. Level 0 is innermost. Each level holds a base
// register that advances by its step; a level is last once base + step reaches
// its dimension. On advance the innermost non-last level steps and every level
// inside it returns to zero. When all levels are last, advance is ignored so the
// bases hold their final values.
module tile_nest_counter #(
    parameter int CW = 16,
    parameter int D0 = 32,
    parameter int S0 = 16,
    parameter int D1 = 32,
    parameter int S1 = 16,
    parameter int D2 = 32,
    parameter int S2 = 16,
    parameter int D3 = 64,
    parameter int S3 = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    output logic [3:0][CW-1:0] base,
    output logic               inner_last,
    output logic               all_last
);

    localparam logic [3:0][CW:0] DIM_W  = {(CW+1)'(D3), (CW+1)'(D2), (CW+1)'(D1), (CW+1)'(D0)};
    localparam logic [3:0][CW:0] STEP_W = {(CW+1)'(S3), (CW+1)'(S2), (CW+1)'(S1), (CW+1)'(S0)};

    logic [3:0][CW-1:0] base_q;
    logic [3:0][CW-1:0] base_d;
    logic [3:0]         last;

    // Last flag per level, compared one bit wider so base + step cannot wrap
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            last[i] = ({1'b0, base_q[i]} + STEP_W[i]) >= DIM_W[i];
        end
    end

    // Ripple the advance from the innermost level outward
    always_comb begin
        logic carry;
        base_d = base_q;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (last[i]) begin
                    base_d[i] = '0;
                end else begin
                    base_d[i] = base_q[i] + STEP_W[i][CW-1:0];
                    carry     = 1'b0;
                end
            end
        end
        if (&last) begin
            base_d = base_q;
        end
    end

    // Base registers: cleared at layer start, stepped on advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
        end else if (clear) begin
            base_q <= '0;
        end else if (advance) begin
            base_q <= base_d;
        end
    end

    assign base       = base_q;
    assign inner_last = last[0];
    assign all_last   = &last;

endmodule

// File: rtl/weight_tile_scheduler.sv
// Weight tile scheduler: walks the (r, c, m, n) tile nest, requests each weight
// tile, counts filter pushes until the tile is complete, then launches compute
// and waits for it before advancing. All outputs are decoded from registers.
module weight_tile_scheduler
    import weight_tile_scheduler_pkg::*;
#(
    parameter int CW = 16,
    parameter int N  = 32,
    parameter int M  = 32,
    parameter int R  = 64,
    parameter int C  = 32,
    parameter int K  = 3,
    parameter int Tn = 16,
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          wt_load_start,
    input  logic          wt_push,
    output logic          compute_start,
    input  logic          compute_done,
    output logic [CW-1:0] tile_base_r,
    output logic [CW-1:0] tile_base_c,
    output logic [CW-1:0] tile_base_m,
    output logic [CW-1:0] tile_base_n,
    output logic          first_n,
    output logic          last_n,
    output logic          err_push
);

    localparam int            WORDS    = words_per_tile(K, Tm, Tn);
    localparam logic [CW-1:0] WORDS_M1 = CW'(WORDS - 1);

    if (N >= (1 << CW) || M >= (1 << CW) || R >= (1 << CW) || C >= (1 << CW) ||
        WORDS > (1 << CW)) begin : g_bad_dims
        $error("weight_tile_scheduler: a dimension or the tile word count does not fit in CW bits");
    end

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q;
    logic               nest_clear;
    logic               nest_adv;
    logic               nest_all_last;
    logic               nest_inner_last;
    logic [3:0][CW-1:0] nest_base;

    tile_nest_counter #(
        .CW (CW),
        .D0 (N),  .S0 (Tn),
        .D1 (M),  .S1 (Tm),
        .D2 (C),  .S2 (Tc),
        .D3 (R),  .S3 (Tr)
    ) u_nest (
        .clk        (clk),
        .rst        (rst),
        .clear      (nest_clear),
        .advance    (nest_adv),
        .base       (nest_base),
        .inner_last (nest_inner_last),
        .all_last   (nest_all_last)
    );

    // State and push counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sticky flag for weight pushes arriving when no tile load is pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (wt_push && (state_q != S_WAIT_LOAD)) begin
            err_q <= 1'b1;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        nest_clear    = 1'b0;
        nest_adv      = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        wt_load_start = 1'b0;
        compute_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nest_clear = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                busy          = 1'b1;
                wt_load_start = 1'b1;
                cnt_d         = '0;
                state_d       = S_WAIT_LOAD;
            end
            S_WAIT_LOAD: begin
                busy = 1'b1;
                if (wt_push) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == WORDS_M1) begin
                        state_d = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                busy          = 1'b1;
                compute_start = 1'b1;
                state_d       = S_WAIT_COMP;
            end
            S_WAIT_COMP: begin
                busy = 1'b1;
                if (compute_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                busy = 1'b1;
                if (nest_all_last) begin
                    state_d = S_DONE;
                end else begin
                    nest_adv = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tile_base_n = nest_base[0];
    assign tile_base_m = nest_base[1];
    assign tile_base_c = nest_base[2];
    assign tile_base_r = nest_base[3];
    assign first_n     = (nest_base[0] == '0);
    assign last_n      = nest_inner_last;
    assign err_push    = err_q;

endmodule

// File: tb/tb_weight_tile_scheduler.sv
// Directed bench for weight_tile_scheduler: a default-parameter DUT and an
// M=N=20 DUT run a full layer side by side against loader/compute models, then
// the default DUT is driven by hand through stall, spurious-event and reset cases.
module tb_weight_tile_scheduler;

    localparam int WORDS = 3 * 3 * 16 * 16;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] c;
        logic [15:0] m;
        logic [15:0] n;
        logic        f;
        logic        l;
    } tile_t;

    logic clk;
    logic rst;
    logic start0, start1;
    logic push_m0, cd_m0, push_m1, cd_m1;
    logic man_push, man_cd;
    logic auto0;
    logic push0, cd0;

    logic        busy0, done0, ld0, cs0, fn0, ln0, err0;
    logic [15:0] br0, bc0, bm0, bn0;
    logic        busy1, done1, ld1, cs1, fn1, ln1, err1;
    logic [15:0] br1, bc1, bm1, bn1;

    assign push0 = push_m0 | man_push;
    assign cd0   = cd_m0 | man_cd;

    weight_tile_scheduler u_dut0 (
        .clk (clk), .rst (rst), .start (start0), .busy (busy0), .done (done0),
        .wt_load_start (ld0), .wt_push (push0), .compute_start (cs0), .compute_done (cd0),
        .tile_base_r (br0), .tile_base_c (bc0), .tile_base_m (bm0), .tile_base_n (bn0),
        .first_n (fn0), .last_n (ln0), .err_push (err0)
    );

    weight_tile_scheduler #(.M (20), .N (20)) u_dut1 (
        .clk (clk), .rst (rst), .start (start1), .busy (busy1), .done (done1),
        .wt_load_start (ld1), .wt_push (push_m1), .compute_start (cs1), .compute_done (cd_m1),
        .tile_base_r (br1), .tile_base_c (bc1), .tile_base_m (bm1), .tile_base_n (bn1),
        .first_n (fn1), .last_n (ln1), .err_push (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_tile(input string tag, input tile_t a, input tile_t e);
        chk({tag, " r"}, a.r, e.r);
        chk({tag, " c"}, a.c, e.c);
        chk({tag, " m"}, a.m, e.m);
        chk({tag, " n"}, a.n, e.n);
        chk({tag, " first_n"}, a.f, e.f);
        chk({tag, " last_n"}, a.l, e.l);
    endtask

    task automatic man_pushes(input int n);
        for (int i = 0; i < n; i++) begin
            man_push = 1'b1;
            @(negedge clk);
        end
        man_push = 1'b0;
    endtask

    // Observed tile bases at each load request, done pulses, busy during done
    tile_t obs0[$];
    tile_t obs1[$];
    int    done_cnt0 = 0, done_cnt1 = 0;
    logic  busy_at_done0 = 1'b0, busy_at_done1 = 1'b0;

    always @(negedge clk) begin
        if (ld0 === 1'b1) obs0.push_back({br0, bc0, bm0, bn0, fn0, ln0});
        if (ld1 === 1'b1) obs1.push_back({br1, bc1, bm1, bn1, fn1, ln1});
        if (done0 === 1'b1) begin
            done_cnt0 <= done_cnt0 + 1;
            if (busy0 !== 1'b0) busy_at_done0 <= 1'b1;
        end
        if (done1 === 1'b1) begin
            done_cnt1 <= done_cnt1 + 1;
            if (busy1 !== 1'b0) busy_at_done1 <= 1'b1;
        end
    end

    // Loader/compute model for DUT0 (active only while auto0 is set)
    initial begin : model0
        int t;
        push_m0 = 1'b0;
        cd_m0   = 1'b0;
        forever begin
            @(negedge clk);
            if (auto0 && ld0 === 1'b1) begin
                @(negedge clk);
                for (int i = 0; i < WORDS; i++) begin
                    push_m0 = 1'b1;
                    @(negedge clk);
                end
                push_m0 = 1'b0;
                t = 0;
                while (cs0 !== 1'b1 && t < 16) begin
                    @(negedge clk);
                    t++;
                end
                repeat (10) @(negedge clk);
                cd_m0 = 1'b1;
                @(negedge clk);
                cd_m0 = 1'b0;
            end
        end
    end

    // Loader/compute model for DUT1
    initial begin : model1
        int t;
        push_m1 = 1'b0;
        cd_m1   = 1'b0;
        forever begin
            @(negedge clk);
            if (ld1 === 1'b1) begin
                @(negedge clk);
                for (int i = 0; i < WORDS; i++) begin
                    push_m1 = 1'b1;
                    @(negedge clk);
                end
                push_m1 = 1'b0;
                t = 0;
                while (cs1 !== 1'b1 && t < 16) begin
                    @(negedge clk);
                    t++;
                end
                repeat (10) @(negedge clk);
                cd_m1 = 1'b1;
                @(negedge clk);
                cd_m1 = 1'b0;
            end
        end
    end

    initial begin : main
        tile_t exp_tbl[8];
        int    t;

        // Expected (r, c, m, n, first_n, last_n) order; identical for M=N=32 and M=N=20
        exp_tbl[0] = {16'd0, 16'd0,  16'd0,  16'd0,  1'b1, 1'b0};
        exp_tbl[1] = {16'd0, 16'd0,  16'd0,  16'd16, 1'b0, 1'b1};
        exp_tbl[2] = {16'd0, 16'd0,  16'd16, 16'd0,  1'b1, 1'b0};
        exp_tbl[3] = {16'd0, 16'd0,  16'd16, 16'd16, 1'b0, 1'b1};
        exp_tbl[4] = {16'd0, 16'd16, 16'd0,  16'd0,  1'b1, 1'b0};
        exp_tbl[5] = {16'd0, 16'd16, 16'd0,  16'd16, 1'b0, 1'b1};
        exp_tbl[6] = {16'd0, 16'd16, 16'd16, 16'd0,  1'b1, 1'b0};
        exp_tbl[7] = {16'd0, 16'd16, 16'd16, 16'd16, 1'b0, 1'b1};

        rst      = 1'b1;
        start0   = 1'b0;
        start1   = 1'b0;
        man_push = 1'b0;
        man_cd   = 1'b0;
        auto0    = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset busy", busy0, 0);
        chk("reset done", done0, 0);
        chk("reset wt_load_start", ld0, 0);
        chk("reset compute_start", cs0, 0);
        chk("reset err_push", err0, 0);
        chk("reset bases", {br0, bc0, bm0, bn0}, 0);

        rst = 1'b0;
        @(negedge clk);

        // Full layer on both DUTs
        start0 = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        chk("start busy", busy0, 1);
        chk("start wt_load_start", ld0, 1);

        // Extra start while busy must not disturb the sequence
        repeat (3000) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;

        t = 0;
        while (!(done_cnt0 >= 1 && done_cnt1 >= 1) && t < 30000) begin
            @(negedge clk);
            t++;
        end
        chk("layer finished in budget", (t < 30000), 1);
        repeat (3) @(negedge clk);

        chk("d0 done pulses", done_cnt0, 1);
        chk("d1 done pulses", done_cnt1, 1);
        chk("d0 busy during done", busy_at_done0, 0);
        chk("d1 busy during done", busy_at_done1, 0);
        chk("d0 busy after done", busy0, 0);
        chk("d1 busy after done", busy1, 0);
        chk("d0 err_push", err0, 0);
        chk("d1 err_push", err1, 0);
        chk("d0 tile count", obs0.size(), 8);
        chk("d1 tile count", obs1.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < obs0.size()) chk_tile($sformatf("d0 tile%0d", i), obs0[i], exp_tbl[i]);
            if (i < obs1.size()) chk_tile($sformatf("d1 tile%0d", i), obs1[i], exp_tbl[i]);
        end
        chk("d0 final bases held", {br0, bc0, bm0, bn0}, {16'd0, 16'd16, 16'd16, 16'd16});

        // Hand-driven DUT0: stall one word short, spurious compute_done
        auto0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("restart wt_load_start", ld0, 1);
        chk("restart bases", {br0, bc0, bm0, bn0}, 0);
        @(negedge clk);
        man_pushes(WORDS - 1);
        repeat (4) @(negedge clk);
        chk("stall no compute_start", cs0, 0);
        man_cd = 1'b1;
        @(negedge clk);
        man_cd = 1'b0;
        @(negedge clk);
        chk("spurious done compute_start", cs0, 0);
        chk("spurious done busy", busy0, 1);
        chk("spurious done wt_load_start", ld0, 0);
        chk("spurious done err_push", err0, 0);

        // Final word: COMPUTE state in the cycle after the push
        man_push = 1'b1;
        @(negedge clk);
        man_push = 1'b0;
        chk("final push compute_start", cs0, 1);
        @(negedge clk);
        chk("compute_start single pulse", cs0, 0);

        // Stray push in WAIT_COMP sets the sticky error
        man_push = 1'b1;
        @(negedge clk);
        man_push = 1'b0;
        @(negedge clk);
        chk("stray push err_push", err0, 1);
        repeat (3) @(negedge clk);
        chk("err_push sticky", err0, 1);
        chk("stray push no compute_start", cs0, 0);

        man_cd = 1'b1;
        @(negedge clk);
        man_cd = 1'b0;
        @(negedge clk);
        chk("tile2 wt_load_start", ld0, 1);
        chk("tile2 bases", {br0, bc0, bm0, bn0}, {16'd0, 16'd0, 16'd0, 16'd16});

        // Tile 2 complete, then tile 3 partially loaded
        @(negedge clk);
        man_pushes(WORDS);
        chk("tile2 compute_start", cs0, 1);
        @(negedge clk);
        man_cd = 1'b1;
        @(negedge clk);
        man_cd = 1'b0;
        @(negedge clk);
        chk("tile3 wt_load_start", ld0, 1);
        chk("tile3 bases", {br0, bc0, bm0, bn0}, {16'd0, 16'd0, 16'd16, 16'd0});
        chk("tile3 first_n", fn0, 1);
        chk("err_push sticky tile3", err0, 1);
        @(negedge clk);
        man_pushes(100);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("async rst busy", busy0, 0);
        chk("async rst wt_load_start", ld0, 0);
        chk("async rst compute_start", cs0, 0);
        chk("async rst err_push", err0, 0);
        chk("async rst bases", {br0, bc0, bm0, bn0}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("post-rst wt_load_start", ld0, 1);
        chk("post-rst bases", {br0, bc0, bm0, bn0}, 0);
        @(negedge clk);
        man_pushes(WORDS - 1);
        chk("post-rst one short no compute_start", cs0, 0);
        man_push = 1'b1;
        @(negedge clk);
        man_push = 1'b0;
        chk("post-rst full tile compute_start", cs0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
